ofs_fim_axi_txn_arb: RTL
========================

Name: ofs_fim_axi_txn_arb

Overview:
Round-robin transaction arbiter that shares one AXI FIM-clock-domain resource (e.g. a single AXI-lite CSR master port) between NUM_REQ requesters. It grants one requester at a time and holds the grant until the resource signals completion. A microsecond watchdog, derived from the FIM clock frequency, aborts hung transactions. It sits between the requester muxes and the shared AXI port, entirely in the 400 MHz FIM clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
CLK_HZ, ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ (400000000), clock frequency used to build the 1 us tick
TIMEOUT_US, 100, watchdog limit in microseconds (1..1023)

Ports:
clk  in  1  FIM clock; one clock only
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request per requester
done  in  1  one-cycle pulse from the resource: current transaction finished
grant  out  NUM_REQ  one-hot grant, registered
grant_idx  out  $clog2(NUM_REQ)  index of the current grantee
busy  out  1  grant active
abort  out  1  one-cycle pulse: the watchdog expired and the resource must drop the transaction
abort_idx  out  $clog2(NUM_REQ)  grantee at abort, held until the next abort
timeout_cnt  out  16  count of aborts, saturating at 16'hFFFF

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE, grant=0, grant_idx=0, busy=0, abort=0, abort_idx=0, timeout_cnt=0, rr_ptr=0, tick prescaler=0, us counter=0.
- Prescaler: TICK_DIV = CLK_HZ/1_000_000 (400). It counts 0..TICK_DIV-1 only while in GRANT. Wrapping produces us_tick. The prescaler and us counter are cleared on every new grant, so the timeout fires exactly TIMEOUT_US*TICK_DIV cycles after grant assertion.
- States:
  - IDLE: if any req is set, pick the first set bit searching from rr_ptr upward with wrap. Next cycle: grant one-hot, busy=1, go to GRANT. Latency is req to grant of 1 cycle.
  - GRANT: hold the grant regardless of req. Dropping req does not end the grant.
    - done=1: clear grant/busy next cycle, rr_ptr = grant_idx+1 (wraps to 0 at NUM_REQ), go to IDLE.
    - us counter reaches TIMEOUT_US with done=0: go to ABORT.
    - done and expiry in the same cycle: done wins, no abort.
  - ABORT: for one cycle, abort=1 and abort_idx=grant_idx. timeout_cnt increments (saturating). Grant is cleared, rr_ptr advances as for done, then go to IDLE.
- done while IDLE or ABORT is ignored.
- After release, IDLE takes at least 1 cycle before the next grant. Back-to-back grants are therefore spaced by 1 idle cycle.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 transactions.
- grant is never more than 1-hot. grant!=0 if and only if busy.
- Reset mid-transaction: all outputs drop asynchronously, with no abort pulse.
- Elaboration check: CLK_HZ % 1_000_000 == 0, otherwise $error.

Decomposition:
- Shared package ofs_fim_arb_pkg:
  - US_TICK_DIV = ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ/1_000_000
  - arb_state_e enum {IDLE, GRANT, ABORT}
  - TIMEOUT_CNT_W = 16
- One sub-module: ofs_fim_us_ticker (prescaler with sync clear, outputs us_tick). Reusable by other FIM-domain watchdogs.
- The round-robin pick is a function inside the arbiter.

Test Plan:
- Single request: req=4'b0100 at cycle 0 → grant=4'b0100, grant_idx=2, busy=1 at cycle 1. done at cycle 10 → grant=0 at cycle 11.
- Round robin: req=4'b1111 held, done 5 cycles after each grant → grant order 0,1,2,3,0, with exactly 1 idle cycle between grants.
- Timeout (TIMEOUT_US=2): grant to requester 1 with no done → abort pulses 1 cycle exactly 800 cycles after grant. abort_idx=1, timeout_cnt=1, next grant goes to requester 2.
- Done coincident with expiry: done pulsed on cycle 800 → no abort, timeout_cnt unchanged.
- Requester drops req mid-grant and stray done while IDLE → grant held until done, stray done ignored, rr_ptr unchanged.
- Async reset at cycle 300 of a grant → grant/busy/abort drop immediately, no abort pulse. After release, req=4'b0001 → grant to 0.

Source files
------------

// File: rtl/ofs_axi_fim_clk_pkg.sv
// FIM clock-domain constants shared by blocks running on the 400 MHz AXI FIM clock.
package ofs_axi_fim_clk_pkg;
    localparam int unsigned AXI_FIM_CLK_HZ = 400_000_000;
endpackage

// File: rtl/ofs_fim_arb_pkg.sv
// Types and constants for the FIM AXI transaction arbiter and its watchdog.
package ofs_fim_arb_pkg;
    localparam int unsigned US_TICK_DIV   = ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ / 1_000_000;
    localparam int          TIMEOUT_CNT_W = 16;
    // Wide enough for the largest supported watchdog limit (1023 us).
    localparam int          US_CNT_W      = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;
endpackage

// File: rtl/ofs_fim_us_ticker.sv
// Microsecond prescaler: pulses us_tick on the last cycle of each DIV-cycle window.
// A synchronous clear restarts the window so a watchdog can be armed at any point.
module ofs_fim_us_ticker #(
    parameter int unsigned DIV = ofs_fim_arb_pkg::US_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic us_tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;
    logic         at_wrap;

    assign at_wrap = (cnt == W'(DIV - 1));
    assign us_tick = en && !clr && at_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= at_wrap ? '0 : cnt + W'(1);
    end
endmodule

// File: rtl/ofs_fim_axi_txn_arb.sv
// Round-robin arbiter granting one requester at a time to a shared FIM AXI resource,
// holding the grant until done, with a microsecond watchdog that aborts hung transactions.
module ofs_fim_axi_txn_arb
    import ofs_fim_arb_pkg::*;
#(
    parameter  int          NUM_REQ    = 4,
    parameter  int unsigned CLK_HZ     = ofs_axi_fim_clk_pkg::AXI_FIM_CLK_HZ,
    parameter  int          TIMEOUT_US = 100,
    localparam int          IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic                     done,
    output logic [NUM_REQ-1:0]       grant,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy,
    output logic                     abort,
    output logic [IDX_W-1:0]         abort_idx,
    output logic [TIMEOUT_CNT_W-1:0] timeout_cnt
);
    localparam int unsigned TICK_DIV = CLK_HZ / 1_000_000;

    if (CLK_HZ % 1_000_000 != 0) begin : g_clk_chk
        $error("ofs_fim_axi_txn_arb: CLK_HZ must be a whole number of MHz");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_req_chk
        $error("ofs_fim_axi_txn_arb: NUM_REQ must be 2..16");
    end
    if (TIMEOUT_US < 1 || TIMEOUT_US > 1023) begin : g_to_chk
        $error("ofs_fim_axi_txn_arb: TIMEOUT_US must be 1..1023");
    end

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       arst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign arst_n = rst_sync[1];

    arb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [US_CNT_W-1:0] us_cnt;
    logic                us_tick;
    logic                expire;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    ptr_after;

    // First set request at or after ptr, wrapping; the lowest offset wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   ptr);
        int               j;
        logic [IDX_W-1:0] k;
        rr_pick = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            k = IDX_W'(j);
            if (r[k]) rr_pick = k;
        end
    endfunction

    assign pick_idx  = rr_pick(req, rr_ptr);
    assign ptr_after = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    // Fires on the last cycle of the window so ABORT lands TIMEOUT_US*TICK_DIV cycles after grant.
    assign expire    = us_tick && (us_cnt == US_CNT_W'(TIMEOUT_US - 1));

    ofs_fim_us_ticker #(.DIV(TICK_DIV)) u_ticker (
        .clk     (clk),
        .rst_n   (arst_n),
        .en      (state == GRANT),
        .clr     (state != GRANT),
        .us_tick (us_tick)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            busy        <= 1'b0;
            abort       <= 1'b0;
            abort_idx   <= '0;
            timeout_cnt <= '0;
            rr_ptr      <= '0;
            us_cnt      <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    us_cnt <= '0;
                    if (|req) begin
                        grant_idx <= pick_idx;
                        grant     <= NUM_REQ'(1) << pick_idx;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (done) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= ptr_after;
                        us_cnt <= '0;
                        state  <= IDLE;
                    end else if (expire) begin
                        grant       <= '0;
                        busy        <= 1'b0;
                        rr_ptr      <= ptr_after;
                        us_cnt      <= '0;
                        abort       <= 1'b1;
                        abort_idx   <= grant_idx;
                        timeout_cnt <= (&timeout_cnt) ? timeout_cnt
                                                      : timeout_cnt + TIMEOUT_CNT_W'(1);
                        state       <= ABORT;
                    end else if (us_tick) begin
                        us_cnt <= us_cnt + US_CNT_W'(1);
                    end
                end
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
